// File: rtl/legofpga_bringup_seq.sv
// Bring-up sequencer: filters clock-wizard lock, sequences PHY reset and settle, issues one
// control word over a valid/ready handshake, then releases MAC and application resets.
module legofpga_bringup_seq #(
  parameter int unsigned LOCK_FILT_CYC   = 1024,
  parameter int unsigned PHY_RST_CYC     = 1250,
  parameter int unsigned PHY_SETTLE_CYC  = 62500,
  parameter logic [3:0]  CFG_WORD        = 4'h1,
  parameter int unsigned CFG_TIMEOUT_CYC = 1250000,
  parameter int unsigned CNT_W           = 21
) (
  input  logic       clk_125,
  input  logic       sys_rst_n,
  input  logic       mmcm_locked_i,
  output logic       phy_rst_n,
  output logic       start_config,
  output logic [3:0] control_data,
  output logic       control_valid,
  input  logic       control_ready,
  output logic       mac_rst_n,
  output logic       app_rst_n,
  output logic [2:0] seq_state,
  output logic       seq_error
);

  // Handshake: a word transfers on a rising clk_125 edge where control_valid and control_ready
  // are both high; control_valid/control_data stay stable until then, and valid drops next cycle.

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd0,
    S_PHY_RST    = 3'd1,
    S_PHY_SETTLE = 3'd2,
    S_CFG_START  = 3'd3,
    S_CFG_SEND   = 3'd4,
    S_RUN        = 3'd5
  } state_e;

  // A zero-length phase would underflow the counter, so treat it as a single cycle.
  localparam int unsigned LF_EFF = (LOCK_FILT_CYC   == 0) ? 1 : LOCK_FILT_CYC;
  localparam int unsigned PR_EFF = (PHY_RST_CYC     == 0) ? 1 : PHY_RST_CYC;
  localparam int unsigned PS_EFF = (PHY_SETTLE_CYC  == 0) ? 1 : PHY_SETTLE_CYC;
  localparam int unsigned TO_EFF = (CFG_TIMEOUT_CYC == 0) ? 1 : CFG_TIMEOUT_CYC;

  localparam logic [CNT_W-1:0] LF_LAST   = CNT_W'(LF_EFF - 1);
  localparam logic [CNT_W-1:0] PR_LOAD   = CNT_W'(PR_EFF);
  localparam logic [CNT_W-1:0] PS_LOAD   = CNT_W'(PS_EFF);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(TO_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync1_d;
  logic             lock_s_q, lock_s_d;
  logic             phy_rst_n_q, phy_rst_n_d;
  logic             start_config_q, start_config_d;
  logic [3:0]       control_data_q, control_data_d;
  logic             control_valid_q, control_valid_d;
  logic             mac_rst_n_q, mac_rst_n_d;
  logic             app_rst_n_q, app_rst_n_d;
  logic             seq_error_q, seq_error_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    sync1_d         = mmcm_locked_i;
    lock_s_d        = sync1_q;
    phy_rst_n_d     = phy_rst_n_q;
    start_config_d  = 1'b0;
    control_data_d  = control_data_q;
    control_valid_d = control_valid_q;
    mac_rst_n_d     = mac_rst_n_q;
    app_rst_n_d     = app_rst_n_q;
    seq_error_d     = seq_error_q;

    // Lock loss outranks every other transition, including a handshake in the same cycle.
    if (state_q != S_WAIT_LOCK && !lock_s_q) begin
      state_d         = S_WAIT_LOCK;
      cnt_d           = '0;
      phy_rst_n_d     = 1'b0;
      control_valid_d = 1'b0;
      control_data_d  = 4'h0;
      mac_rst_n_d     = 1'b0;
      app_rst_n_d     = 1'b0;
    end else begin
      unique case (state_q)
        S_WAIT_LOCK: begin
          phy_rst_n_d     = 1'b0;
          control_valid_d = 1'b0;
          control_data_d  = 4'h0;
          mac_rst_n_d     = 1'b0;
          app_rst_n_d     = 1'b0;
          if (!lock_s_q) begin
            cnt_d = '0;
          end else if (cnt_q >= LF_LAST) begin
            state_d = S_PHY_RST;
            cnt_d   = PR_LOAD;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        S_PHY_RST: begin
          if (cnt_q <= CNT_ONE) begin
            state_d     = S_PHY_SETTLE;
            cnt_d       = PS_LOAD;
            phy_rst_n_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_PHY_SETTLE: begin
          if (cnt_q <= CNT_ONE) begin
            state_d        = S_CFG_START;
            start_config_d = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_CFG_START: begin
          state_d         = S_CFG_SEND;
          cnt_d           = TO_LOAD;
          control_valid_d = 1'b1;
          control_data_d  = CFG_WORD;
        end
        S_CFG_SEND: begin
          if (control_valid_q && control_ready) begin
            state_d         = S_RUN;
            control_valid_d = 1'b0;
            control_data_d  = 4'h0;
          end else if (cnt_q <= CNT_ONE) begin
            // Timed out: flag it and retry from a fresh start_config pulse.
            state_d         = S_CFG_START;
            start_config_d  = 1'b1;
            control_valid_d = 1'b0;
            control_data_d  = 4'h0;
            seq_error_d     = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_RUN: begin
          mac_rst_n_d = 1'b1;
          app_rst_n_d = mac_rst_n_q;
        end
        default: begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_125 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q         <= S_WAIT_LOCK;
      cnt_q           <= '0;
      sync1_q         <= 1'b0;
      lock_s_q        <= 1'b0;
      phy_rst_n_q     <= 1'b0;
      start_config_q  <= 1'b0;
      control_data_q  <= 4'h0;
      control_valid_q <= 1'b0;
      mac_rst_n_q     <= 1'b0;
      app_rst_n_q     <= 1'b0;
      seq_error_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sync1_q         <= sync1_d;
      lock_s_q        <= lock_s_d;
      phy_rst_n_q     <= phy_rst_n_d;
      start_config_q  <= start_config_d;
      control_data_q  <= control_data_d;
      control_valid_q <= control_valid_d;
      mac_rst_n_q     <= mac_rst_n_d;
      app_rst_n_q     <= app_rst_n_d;
      seq_error_q     <= seq_error_d;
    end
  end

  assign phy_rst_n     = phy_rst_n_q;
  assign start_config  = start_config_q;
  assign control_data  = control_data_q;
  assign control_valid = control_valid_q;
  assign mac_rst_n     = mac_rst_n_q;
  assign app_rst_n     = app_rst_n_q;
  assign seq_state     = state_q;
  assign seq_error     = seq_error_q;

endmodule
